// File: rtl/music_pkg.sv
// Shared opcode constants, instruction classes and the classifier used by the prefetch stage.
package music_pkg;

    localparam logic [3:0]  OP_END          = 4'b0000;
    localparam logic [3:0]  OP_BPM          = 4'b0001;
    localparam int          NOTE_BIT        = 15;
    localparam logic [15:0] PLACEHOLDER_INS = 16'h8001;

    typedef enum logic [1:0] {CLS_NOTE, CLS_BPM, CLS_END, CLS_INVALID} ins_class_e;

    typedef enum logic {ST_FETCH, ST_STOPPED} fetch_state_e;

    function automatic ins_class_e classify(input logic [15:0] w);
        if (w[15:12] == OP_END)      return CLS_END;
        else if (w[15:12] == OP_BPM) return CLS_BPM;
        else if (w[NOTE_BIT])        return CLS_NOTE;
        else                         return CLS_INVALID;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO, DEPTH a power of two; head is registered storage, visible the edge after push.
// Push into a full FIFO is accepted only together with a pop; flush empties it on the next edge.
module ins_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dat_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ins_prefetch.sv
// Sequential instruction prefetch from wait-stated SRAM into ins_fifo; stops after END.
// Optional macro INS_PREFETCH_DROP_INVALID_EN discards invalid words and counts them in dropped_o.
module ins_prefetch
    import music_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restart_i,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [15:0]       sram_d_i,
    output logic [15:0]       ins_o,
    output logic              ins_valid_o,
    input  logic              ins_ready_i,
    output logic              halted_o,
    output logic [7:0]        dropped_o
);

    localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [2:0]            c_q, c_d;
    ins_class_e            cls;
    logic                  push, pop, free;
    logic [15:0]           fifo_head;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                  fifo_empty, fifo_full;
`ifdef INS_PREFETCH_DROP_INVALID_EN
    logic                  drop_inc;
    logic [7:0]            dropped_q;
`endif

    // A pop in the restart cycle is discarded by the flush anyway; masking it keeps free honest.
    assign pop  = !fifo_empty && ins_ready_i && !restart_i;
    assign free = !fifo_full || pop;
    assign cls  = classify(sram_d_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        c_d     = c_q;
        push    = 1'b0;
`ifdef INS_PREFETCH_DROP_INVALID_EN
        drop_inc = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                if (c_q != WAIT_C) begin
                    c_d = c_q + 3'd1;
                end else if (free) begin
                    pc_d = pc_q + ADDR_W'(1);
                    c_d  = 3'd0;
`ifdef INS_PREFETCH_DROP_INVALID_EN
                    if (cls == CLS_INVALID) drop_inc = 1'b1;
                    else                    push     = 1'b1;
`else
                    push = 1'b1;
`endif
                    if (cls == CLS_END) state_d = ST_STOPPED;
                end
            end
            default: ;
        endcase
        if (restart_i) begin
            state_d = ST_FETCH;
            pc_d    = '0;
            c_d     = 3'd0;
            push    = 1'b0;
`ifdef INS_PREFETCH_DROP_INVALID_EN
            drop_inc = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            c_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            c_q     <= c_d;
        end
    end

`ifdef INS_PREFETCH_DROP_INVALID_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dropped_q <= 8'd0;
        end else if (drop_inc && dropped_q != 8'hFF) begin
            dropped_q <= dropped_q + 8'd1;
        end
    end
    assign dropped_o = dropped_q;
`else
    assign dropped_o = 8'd0;
`endif

    ins_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (restart_i),
        .push_i  (push),
        .dat_i   (sram_d_i),
        .pop_i   (pop),
        .dat_o   (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign sram_a_o    = pc_q;
    assign ins_valid_o = !fifo_empty;
    assign ins_o       = fifo_empty ? PLACEHOLDER_INS : fifo_head;
    assign halted_o    = (state_q == ST_STOPPED) && (fifo_cnt == '0);

endmodule

// File: tb/tb_ins_prefetch.sv
// Bench for ins_prefetch (ADDR_W=4 so address wrap is reachable); reference model walks the program.
module tb_ins_prefetch;

    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst, restart, ins_ready;
    logic [3:0]  sram_a;
    logic [15:0] sram_d, ins;
    logic        ins_valid, halted;
    logic [7:0]  dropped;

    logic [15:0] mem [16];
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    int          obs_cyc[$];
    int          cyc, exp_drop;
    int          pass_cnt = 0, total_cnt = 0;

    always #10 clk = ~clk;
    assign sram_d = mem[sram_a];

    ins_prefetch #(.DEPTH(4), .ADDR_W(4), .WAIT_CYCLES(WAITC)) dut (
        .clk_i(clk), .rst_i(rst), .restart_i(restart), .sram_a_o(sram_a), .sram_d_i(sram_d),
        .ins_o(ins), .ins_valid_o(ins_valid), .ins_ready_i(ins_ready),
        .halted_o(halted), .dropped_o(dropped)
    );

    // One clock; records the word the consumer takes on this edge.
    task automatic step();
        logic        p;
        logic [15:0] w;
        p = ins_valid && ins_ready && !restart && !rst;
        w = ins;
        @(posedge clk); #1;
        cyc++;
        if (p) begin obs_q.push_back(w); obs_cyc.push_back(cyc); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0; restart = 1'b0;
        cyc = 0; obs_q.delete(); obs_cyc.delete();
    endtask

    // Expected delivered words for the first max_caps captures of the program.
    task automatic build_model(input int max_caps);
        logic [15:0] w;
        exp_q.delete(); exp_drop = 0;
        for (int k = 0; k < max_caps; k++) begin
            w = mem[k % 16];
            if (w[15:12] == 4'h0) begin exp_q.push_back(w); break; end
            else if (w[15:12] == 4'h1 || w[15]) exp_q.push_back(w);
            else begin
`ifdef INS_PREFETCH_DROP_INVALID_EN
                if (exp_drop < 255) exp_drop++;
`else
                exp_q.push_back(w);
`endif
            end
        end
    endtask

    task automatic run_until_halted(input string nm, input int budget);
        int n = 0;
        while (!halted && n < budget) begin step(); n++; end
        total_cnt++;
        if (!halted) $display("FAIL %s timeout: halted=%0b after %0d cycles, required 1", nm, halted, n);
        else pass_cnt++;
    endtask

    task automatic test_reset(input logic dirty);
        if (dirty) begin
            ins_ready = 1'b1;
            for (int i = 0; i < 7; i++) step();
        end
        restart = dirty;
        do_reset();
        total_cnt++; if (sram_a !== 4'd0) $display("FAIL rst_addr: got %h want 0", sram_a); else pass_cnt++;
        total_cnt++; if (ins_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ins_valid); else pass_cnt++;
        total_cnt++; if (ins !== 16'h8001) $display("FAIL rst_ins: got %h want 8001", ins); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (dropped !== 8'd0) $display("FAIL rst_dropped: got %0d want 0", dropped); else pass_cnt++;
    endtask

    task automatic test_basic();
        int first_vld = -1, halt_cyc = -1;
        mem[0] = 16'h8005; mem[1] = 16'h1078; mem[2] = 16'h8123; mem[3] = 16'h0000;
        for (int i = 4; i < 16; i++) mem[i] = 16'h8000 | 16'(i);
        ins_ready = 1'b1;
        do_reset();
        build_model(16);
        for (int i = 0; i < 25; i++) begin
            step();
            if (ins_valid && first_vld < 0) first_vld = cyc;
            if (halted && halt_cyc < 0) halt_cyc = cyc;
        end
        total_cnt++; if (first_vld !== WAITC + 1) $display("FAIL basic_first_valid: got edge %0d want %0d", first_vld, WAITC + 1); else pass_cnt++;
        total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
            // first word visible at WAIT+1, popped one edge later, then one every WAIT+1
            total_cnt++; if (obs_cyc[i] !== WAITC + 2 + (WAITC + 1) * i) $display("FAIL basic_pop_edge%0d: got %0d want %0d", i, obs_cyc[i], WAITC + 2 + (WAITC + 1) * i); else pass_cnt++;
        end
        if (obs_cyc.size() > 0) begin
            total_cnt++; if (halt_cyc !== obs_cyc[obs_cyc.size() - 1]) $display("FAIL basic_halt_edge: got %0d want %0d", halt_cyc, obs_cyc[obs_cyc.size() - 1]); else pass_cnt++;
        end
        total_cnt++; if (sram_a !== 4'd4) $display("FAIL basic_addr_frozen: got %0d want 4", sram_a); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? (16'h8100 + 16'($urandom_range(0, 255))) : 16'h9999;
        mem[10] = 16'h0000;
        ins_ready = 1'b0;
        do_reset();
        build_model(16);
        for (int i = 0; i < 30; i++) step();
        total_cnt++; if (sram_a !== 4'd4) $display("FAIL bp_addr_held: got %0d want 4", sram_a); else pass_cnt++;
        total_cnt++; if (ins_valid !== 1'b1 || ins !== mem[0]) $display("FAIL bp_head: got %b/%h want 1/%h", ins_valid, ins, mem[0]); else pass_cnt++;
        step();
        total_cnt++; if (sram_a !== 4'd4) $display("FAIL bp_addr_still: got %0d want 4", sram_a); else pass_cnt++;
        ins_ready = 1'b1;
        run_until_halted("bp", 200);
        total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_invalid();
        mem[0] = 16'h8001; mem[1] = 16'h2ABC; mem[2] = 16'h4000; mem[3] = 16'h0000;
        ins_ready = 1'b1;
        do_reset();
        build_model(16);
        run_until_halted("inv", 100);
        total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL inv_count: got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL inv_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
        end
        total_cnt++; if (dropped !== 8'(exp_drop)) $display("FAIL inv_dropped: got %0d want %0d", dropped, exp_drop); else pass_cnt++;
        // restart while stopped: refetch from 0, drop count survives
        restart = 1'b1; step(); restart = 1'b0;
        total_cnt++; if (halted !== 1'b0 || sram_a !== 4'd0) $display("FAIL inv_restart: got halted=%b addr=%0d want 0/0", halted, sram_a); else pass_cnt++;
        total_cnt++; if (dropped !== 8'(exp_drop)) $display("FAIL inv_dropped_kept: got %0d want %0d", dropped, exp_drop); else pass_cnt++;
        run_until_halted("inv_rerun", 100);
        total_cnt++; if (dropped !== 8'(2 * exp_drop)) $display("FAIL inv_dropped_rerun: got %0d want %0d", dropped, 2 * exp_drop); else pass_cnt++;
    endtask

    task automatic test_restart();
        for (int i = 0; i < 16; i++) mem[i] = 16'hC000 + 16'($urandom_range(0, 4095));
        ins_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        total_cnt++; if (sram_a !== 4'd3) $display("FAIL rs_pre_addr: got %0d want 3", sram_a); else pass_cnt++;
        restart = 1'b1; step(); restart = 1'b0;
        total_cnt++; if (ins_valid !== 1'b0 || sram_a !== 4'd0) $display("FAIL rs_flush: got valid=%b addr=%0d want 0/0", ins_valid, sram_a); else pass_cnt++;
        for (int i = 0; i < WAITC; i++) step();
        total_cnt++; if (ins_valid !== 1'b0) $display("FAIL rs_early: got valid=%b want 0", ins_valid); else pass_cnt++;
        step();
        total_cnt++; if (ins_valid !== 1'b1 || ins !== mem[0]) $display("FAIL rs_refetch: got %b/%h want 1/%h", ins_valid, ins, mem[0]); else pass_cnt++;
    endtask

    task automatic test_wrap_saturate();
        logic [3:0] prev;
        logic       wrapped = 1'b0, cont = 1'b0;
        int         exp_pops;
        for (int i = 0; i < 16; i++) mem[i] = 16'h2A00 + 16'(i);
        ins_ready = 1'b1;
        do_reset();
        prev = sram_a;
        for (int i = 0; i < 900; i++) begin
            step();
            if (prev == 4'd15 && sram_a == 4'd0) wrapped = 1'b1;
            if (wrapped && sram_a == 4'd1) cont = 1'b1;
            prev = sram_a;
        end
        build_model(300);
        // the 300th capture is still at the head, not yet popped
        exp_pops = (exp_q.size() == 0) ? 0 : exp_q.size() - 1;
        total_cnt++; if (cont !== 1'b1) $display("FAIL wrap_seen: got %b want 1", cont); else pass_cnt++;
        total_cnt++; if (sram_a !== 4'(300 % 16)) $display("FAIL wrap_addr: got %0d want %0d", sram_a, 300 % 16); else pass_cnt++;
        total_cnt++; if (dropped !== 8'(exp_drop)) $display("FAIL sat_dropped: got %0d want %0d", dropped, exp_drop); else pass_cnt++;
        total_cnt++; if (obs_q.size() !== exp_pops) $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_pops); else pass_cnt++;
        for (int i = 0; i < exp_pops && i < obs_q.size(); i += 37) begin
            total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; ins_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h8000;
        test_reset(1'b0);
        test_basic();
        test_backpressure();
        test_invalid();
        test_restart();
        test_wrap_saturate();
        test_reset(1'b1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
